// File: rtl/bdb_bounce_generator.sv
// rtl/bdb_bounce_generator.sv - multi-channel contact-bounce stimulus engine
// Each accepted op drives one channel through B glitches, then a D-cycle hold at the target level.
module bdb_bounce_generator #(
   parameter int          NUM_CH    = 4,
   parameter int          BOUNCE_W  = 4,
   parameter int          DUR_W     = 8,
   parameter int          CNT_W     = 16,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                op_valid,
   output logic                op_ready,
   input  logic [CH_W-1:0]     op_ch,
   input  logic                op_kind,
   input  logic [BOUNCE_W-1:0] op_bounces,
   input  logic [DUR_W-1:0]    op_duration,
   input  logic                mode_random,
   output logic [NUM_CH-1:0]   button_out,
   output logic                busy,
   output logic                op_done,
   output logic                op_error,
   output logic [CNT_W-1:0]    ops_count
);

   localparam int CW0 = (BOUNCE_W > DUR_W) ? BOUNCE_W : DUR_W;
   localparam int CW  = (CW0 > 3) ? CW0 : 3;

   typedef enum logic [2:0] {
      IDLE, BOUNCE_ON, BOUNCE_OFF, HOLD, DONE, ERR
   } state_t;

   state_t              state_q, state_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic                tgt_q, tgt_d;
   logic                rnd_q, rnd_d;
   logic [BOUNCE_W-1:0] k_q, k_d;
   logic [DUR_W-1:0]    dur_q, dur_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NUM_CH-1:0]   btn_q, btn_d;
   logic [CNT_W-1:0]    ops_q, ops_d;
   logic [15:0]         lfsr_q;

   logic          set_en;
   logic          set_lvl;
   logic [CW-1:0] rnd_w;

   assign rnd_w = CW'(lfsr_q[2:0]) + CW'(1);

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      tgt_d   = tgt_q;
      rnd_d   = rnd_q;
      k_d     = k_q;
      dur_d   = dur_q;
      cnt_d   = cnt_q;
      set_en  = 1'b0;
      set_lvl = 1'b0;
      ops_d   = ops_q;
      btn_d   = btn_q;

      case (state_q)
         IDLE: begin
            if (op_valid) begin
               ch_d  = op_ch;
               tgt_d = op_kind;
               rnd_d = mode_random;
               k_d   = op_bounces;
               dur_d = op_duration;
               if (int'(op_ch) >= NUM_CH) begin
                  state_d = ERR;
               end else begin
                  set_en  = 1'b1;
                  set_lvl = op_kind;
                  if (op_bounces != '0) begin
                     state_d = BOUNCE_ON;
                     cnt_d   = (mode_random ? rnd_w : CW'(op_bounces)) - CW'(1);
                  end else if (op_duration != '0) begin
                     state_d = HOLD;
                     cnt_d   = CW'(op_duration) - CW'(1);
                  end else begin
                     state_d = DONE;
                  end
               end
            end
         end
         BOUNCE_ON: begin
            if (cnt_q == '0) begin
               state_d = BOUNCE_OFF;
               set_en  = 1'b1;
               set_lvl = ~tgt_q;
               cnt_d   = (rnd_q ? rnd_w : CW'(k_q)) - CW'(1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         BOUNCE_OFF: begin
            if (cnt_q == '0) begin
               k_d     = k_q - BOUNCE_W'(1);
               set_en  = 1'b1;
               set_lvl = tgt_q;
               // k_q == 1 means this was the last glitch
               if (k_q != BOUNCE_W'(1)) begin
                  state_d = BOUNCE_ON;
                  cnt_d   = (rnd_q ? rnd_w : CW'(k_q - BOUNCE_W'(1))) - CW'(1);
               end else if (dur_q != '0) begin
                  state_d = HOLD;
                  cnt_d   = CW'(dur_q) - CW'(1);
               end else begin
                  state_d = DONE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         HOLD: begin
            if (cnt_q == '0) state_d = DONE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         DONE: begin
            state_d = IDLE;
            if (~&ops_q) ops_d = ops_q + CNT_W'(1);
         end
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (set_en) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_d == CH_W'(i)) btn_d[i] = set_lvl;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ch_q    <= '0;
         tgt_q   <= 1'b0;
         rnd_q   <= 1'b0;
         k_q     <= '0;
         dur_q   <= '0;
         cnt_q   <= '0;
         btn_q   <= '0;
         ops_q   <= '0;
         lfsr_q  <= LFSR_SEED;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         tgt_q   <= tgt_d;
         rnd_q   <= rnd_d;
         k_q     <= k_d;
         dur_q   <= dur_d;
         cnt_q   <= cnt_d;
         btn_q   <= btn_d;
         ops_q   <= ops_d;
         lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   assign op_ready   = (state_q == IDLE) && !reset;
   assign busy       = (state_q != IDLE);
   assign op_done    = (state_q == DONE);
   assign op_error   = (state_q == ERR);
   assign button_out = btn_q;
   assign ops_count  = ops_q;

endmodule

// File: tb/tb_bdb_bounce_generator.sv
// tb/tb_bdb_bounce_generator.sv - randomized self-checking bench for bdb_bounce_generator
module tb_bdb_bounce_generator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1;
   logic       op_valid = 1'b0, op_ready, op_kind = 1'b0, mode_random = 1'b0;
   logic [1:0] op_ch = '0;
   logic [3:0] op_bounces = '0;
   logic [7:0] op_duration = '0;
   logic [3:0] button_out;
   logic       busy, op_done, op_error;
   logic [15:0] ops_count;

   logic       b_reset = 1'b1;
   logic       b_op_valid = 1'b0, b_op_ready, b_op_kind = 1'b0;
   logic [2:0] b_op_ch = '0;
   logic [3:0] b_op_bounces = '0;
   logic [7:0] b_op_duration = '0;
   logic [4:0] b_button_out;
   logic       b_busy, b_op_done, b_op_error;
   logic [3:0] b_ops_count;

   bdb_bounce_generator dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
      .op_ch(op_ch), .op_kind(op_kind), .op_bounces(op_bounces),
      .op_duration(op_duration), .mode_random(mode_random),
      .button_out(button_out), .busy(busy), .op_done(op_done),
      .op_error(op_error), .ops_count(ops_count)
   );

   bdb_bounce_generator #(.NUM_CH(5), .CNT_W(4)) dut2 (
      .clk(clk), .reset(b_reset), .op_valid(b_op_valid), .op_ready(b_op_ready),
      .op_ch(b_op_ch), .op_kind(b_op_kind), .op_bounces(b_op_bounces),
      .op_duration(b_op_duration), .mode_random(1'b0),
      .button_out(b_button_out), .busy(b_busy), .op_done(b_op_done),
      .op_error(b_op_error), .ops_count(b_ops_count)
   );

   int   checks = 0;
   int   errors = 0;
   logic model_btn [4];
   int   exp_count = 0;
   logic samp_lvl [$];
   logic samp_done [$];
   logic exp_q [$];
   bit   other_bad;

   function automatic logic [3:0] model_vec();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = model_btn[i];
      return v;
   endfunction

   // Expected per-cycle level of the selected channel: glitch pairs of width B..1, hold D, done 1.
   function automatic void build_exp(input logic kind, input int b, input int d);
      exp_q.delete();
      for (int k = b; k >= 1; k--) begin
         for (int j = 0; j < k; j++) exp_q.push_back(kind);
         for (int j = 0; j < k; j++) exp_q.push_back(~kind);
      end
      for (int j = 0; j < d + 1; j++) exp_q.push_back(kind);
   endfunction

   task automatic run_op(input int ch, input logic kind, input int b, input int d, input logic rnd);
      logic [3:0] mask;
      int guard;
      mask = 4'b0001 << ch;
      @(negedge clk);
      op_ch = 2'(ch); op_kind = kind; op_bounces = 4'(b); op_duration = 8'(d);
      mode_random = rnd; op_valid = 1'b1;
      checks++;
      if (op_ready !== 1'b1) begin
         errors++; $display("FAIL op_ready_before_accept: got %b want 1", op_ready);
      end
      @(negedge clk);
      op_valid = 1'b0;
      samp_lvl.delete(); samp_done.delete(); other_bad = 1'b0; guard = 0;
      while (busy === 1'b1 && guard < 2000) begin
         samp_lvl.push_back(button_out[ch]);
         samp_done.push_back(op_done);
         if ((button_out & ~mask) !== (model_vec() & ~mask)) other_bad = 1'b1;
         guard++;
         @(negedge clk);
      end
      checks++;
      if (guard >= 2000) begin
         errors++; $display("FAIL op_timeout: busy stuck after %0d cycles", guard);
      end
      checks++;
      if (other_bad) begin
         errors++; $display("FAIL other_channels: ch %0d op disturbed others, now %b want %b",
                            ch, button_out & ~mask, model_vec() & ~mask);
      end
      model_btn[ch] = kind;
      exp_count++;
   endtask

   task automatic check_seq(input string name);
      int bad_i;
      bad_i = -1;
      for (int i = 0; i < exp_q.size() && i < samp_lvl.size(); i++)
         if (bad_i < 0 && samp_lvl[i] !== exp_q[i]) bad_i = i;
      checks++;
      if (samp_lvl.size() != exp_q.size() || bad_i >= 0) begin
         errors++;
         $display("FAIL %s_wave: len %0d want %0d, first diff at %0d", name,
                  samp_lvl.size(), exp_q.size(), bad_i);
      end
      bad_i = -1;
      for (int i = 0; i < samp_done.size(); i++)
         if (samp_done[i] !== (i == samp_done.size() - 1)) bad_i = i;
      checks++;
      if (bad_i >= 0) begin
         errors++; $display("FAIL %s_done: op_done wrong at cycle %0d of %0d", name, bad_i, samp_done.size());
      end
   endtask

   task automatic check_count(input string name);
      checks++;
      if (ops_count !== 16'(exp_count)) begin
         errors++; $display("FAIL %s_count: got %0d want %0d", name, ops_count, exp_count);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({button_out, busy, op_done, op_error, op_ready, ops_count} !== 24'h0) begin
         errors++; $display("FAIL reset_outputs: btn %b busy %b done %b err %b rdy %b cnt %0d want all 0",
                            button_out, busy, op_done, op_error, op_ready, ops_count);
      end
      reset = 1'b0; b_reset = 1'b0;
      @(negedge clk);
      checks++;
      if (op_ready !== 1'b1 || b_op_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready: got %b/%b want 1/1", op_ready, b_op_ready);
      end
   endtask

   task automatic test_reset_mid_burst();
      logic seen_done;
      seen_done = 1'b0;
      @(negedge clk);
      op_ch = 2'd2; op_kind = 1'b1; op_bounces = 4'd5; op_duration = 8'd3; mode_random = 1'b0;
      op_valid = 1'b1;
      @(negedge clk);
      op_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (op_done === 1'b1) seen_done = 1'b1;
         @(negedge clk);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({button_out, busy, op_done, op_error, op_ready, ops_count} !== 24'h0 || seen_done) begin
         errors++; $display("FAIL mid_burst_reset: btn %b busy %b done %b rdy %b cnt %0d seen_done %b want all 0",
                            button_out, busy, op_done, op_ready, ops_count, seen_done);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) model_btn[i] = 1'b0;
      exp_count = 0;
      @(negedge clk);
      checks++;
      if (op_ready !== 1'b1 || button_out !== 4'h0) begin
         errors++; $display("FAIL mid_burst_recover: rdy %b btn %b want 1 0000", op_ready, button_out);
      end
      check_count("mid_burst");
   endtask

   task automatic test_press_ch1();
      logic lit [18] = '{1,1,1,0,0,0,1,1,0,0,1,0,1,1,1,1,1,1};
      run_op(1, 1'b1, 3, 5, 1'b0);
      exp_q.delete();
      foreach (lit[i]) exp_q.push_back(lit[i]);
      check_seq("press_ch1");
      check_count("press_ch1");
   endtask

   task automatic test_release_ch1();
      logic lit [9] = '{0,0,1,1,0,1,0,0,0};
      run_op(1, 1'b0, 2, 2, 1'b0);
      exp_q.delete();
      foreach (lit[i]) exp_q.push_back(lit[i]);
      check_seq("release_ch1");
      check_count("release_ch1");
      repeat (3) @(negedge clk);
      checks++;
      if (button_out !== model_vec()) begin
         errors++; $display("FAIL release_stays: btn %b want %b", button_out, model_vec());
      end
   endtask

   task automatic test_zero_burst();
      run_op(3, 1'b1, 0, 0, 1'b0);
      build_exp(1'b1, 0, 0);
      check_seq("zero_burst");
      checks++;
      if (op_ready !== 1'b1 || button_out[3] !== 1'b1) begin
         errors++; $display("FAIL zero_burst_ready: rdy %b btn3 %b want 1 1", op_ready, button_out[3]);
      end
      check_count("zero_burst");
   endtask

   task automatic test_random_det();
      for (int n = 0; n < 40; n++) begin
         int ch, b, d;
         logic kind;
         ch = $urandom_range(0, 3); b = $urandom_range(0, 7); d = $urandom_range(0, 15);
         kind = 1'($urandom_range(0, 1));
         run_op(ch, kind, b, d, 1'b0);
         build_exp(kind, b, d);
         check_seq("det_op");
      end
      check_count("random_det");
   endtask

   task automatic test_random_mode();
      int bad_ops;
      bad_ops = 0;
      for (int n = 0; n < 600; n++) begin
         int ch, b, d, runs [$], len;
         logic kind, ok;
         ch = $urandom_range(0, 3); b = $urandom_range(0, 15); d = $urandom_range(0, 3);
         kind = 1'($urandom_range(0, 1));
         run_op(ch, kind, b, d, 1'b1);
         runs.delete(); len = 0;
         for (int i = 0; i < samp_lvl.size(); i++) begin
            len++;
            if (i == samp_lvl.size() - 1 || samp_lvl[i + 1] !== samp_lvl[i]) begin
               runs.push_back(len); len = 0;
            end
         end
         ok = (runs.size() == 2 * b + 1) && (samp_lvl.size() > 0) && (samp_lvl[0] === kind)
              && (samp_done.size() > 0) && (samp_done[samp_done.size() - 1] === 1'b1);
         if (ok) begin
            for (int i = 0; i < 2 * b; i++) if (runs[i] < 1 || runs[i] > 8) ok = 1'b0;
            if (runs[2 * b] != d + 1) ok = 1'b0;
         end
         if (!ok) begin
            bad_ops++;
            if (bad_ops <= 5) $display("FAIL rnd_op_shape: op %0d B=%0d D=%0d runs %0d want %0d", n, b, d, runs.size(), 2 * b + 1);
         end
      end
      checks++;
      if (bad_ops != 0) begin
         errors++; $display("FAIL random_widths: %0d bad ops want 0", bad_ops);
      end
      checks++;
      if (button_out !== model_vec()) begin
         errors++; $display("FAIL random_final_levels: btn %b want %b", button_out, model_vec());
      end
      check_count("random_mode");
   endtask

   task automatic test_out_of_range();
      @(negedge clk);
      b_op_ch = 3'd5; b_op_kind = 1'b1; b_op_bounces = 4'd2; b_op_duration = 8'd1; b_op_valid = 1'b1;
      @(negedge clk);
      b_op_ch = 3'd0; b_op_bounces = 4'd0; b_op_duration = 8'd0;
      checks++;
      if (b_op_error !== 1'b1 || b_op_ready !== 1'b0 || b_button_out !== 5'h0 || b_op_done !== 1'b0) begin
         errors++; $display("FAIL oor_error: err %b rdy %b btn %b done %b want 1 0 00000 0",
                            b_op_error, b_op_ready, b_button_out, b_op_done);
      end
      @(negedge clk);
      checks++;
      if (b_op_error !== 1'b0 || b_op_ready !== 1'b1 || b_ops_count !== 4'd0) begin
         errors++; $display("FAIL oor_recover: err %b rdy %b cnt %0d want 0 1 0", b_op_error, b_op_ready, b_ops_count);
      end
      @(negedge clk);
      b_op_valid = 1'b0;
      checks++;
      if (b_op_done !== 1'b1 || b_button_out !== 5'b00001) begin
         errors++; $display("FAIL oor_back_to_back: done %b btn %b want 1 00001", b_op_done, b_button_out);
      end
      @(negedge clk);
      checks++;
      if (b_ops_count !== 4'd1) begin
         errors++; $display("FAIL oor_count: got %0d want 1", b_ops_count);
      end
   endtask

   task automatic test_saturation();
      int n_done;
      n_done = 1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         b_op_ch = 3'($urandom_range(0, 4)); b_op_kind = 1'($urandom_range(0, 1));
         b_op_bounces = 4'd0; b_op_duration = 8'd0; b_op_valid = 1'b1;
         @(negedge clk);
         b_op_valid = 1'b0;
         @(negedge clk);
         n_done++;
         checks++;
         if (b_ops_count !== 4'((n_done > 15) ? 15 : n_done)) begin
            errors++; $display("FAIL saturation: after %0d ops got %0d want %0d", n_done, b_ops_count, (n_done > 15) ? 15 : n_done);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) model_btn[i] = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_reset_mid_burst();
      test_press_ch1();
      test_release_ch1();
      test_zero_burst();
      test_random_det();
      test_random_mode();
      test_out_of_range();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
